// File: rtl/booth_mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
//   state_e  : control FSM encoding (IDLE, BUSY, DONE)
//   digit_e  : radix-4 Booth digit (ZERO, POS1, POS2, NEG1, NEG2)
//   n_iter() : radix-4 steps needed for a WIDTH-bit operand pair
//   recode() : triplet {b[2i+1], b[2i], b[2i-1]} -> Booth digit
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_e;

    // Operands are extended to WIDTH+2 bits, consumed two bits per step.
    function automatic int unsigned n_iter(input int unsigned width);
        return width / 2 + 1;
    endfunction

    function automatic digit_e recode(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_r4_if.sv
// Operation/result handshake bundle for booth_mult_r4.
//   flush                      : synchronous abort from issue logic
//   in_valid / in_ready        : operand handshake
//   is_signed, multiplicand,
//   multiplier                 : operation payload
//   out_valid / out_ready      : result handshake
//   result, result_hi, overflow: result payload
// master = issue/consumer side, slave = multiplier.
interface booth_mult_r4_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             overflow;

    modport master (
        output flush, in_valid, is_signed, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, result, result_hi, overflow
    );

    modport slave (
        input  flush, in_valid, is_signed, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, result, result_hi, overflow
    );
endinterface

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial-product generator (combinational).
//   triplet : {b[2i+1], b[2i], b[2i-1]} of the extended multiplier
//   a_ext   : multiplicand extended to WIDTH+2 bits
//   pp      : selected multiple of a_ext at WIDTH+3 bits (inverted for negative digits)
//   cin     : +1 completing the two's-complement negation
module booth_r4_pp_gen
    import booth_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp,
    output logic             cin
);

    logic [WIDTH+2:0] a1;
    logic [WIDTH+2:0] a2;

    always_comb begin
        a1  = {a_ext[WIDTH+1], a_ext};
        a2  = {a_ext, 1'b0};
        pp  = '0;
        cin = 1'b0;
        case (recode(triplet))
            POS1: pp = a1;
            POS2: pp = a2;
            NEG1: begin
                pp  = ~a1;
                cin = 1'b1;
            end
            NEG2: begin
                pp  = ~a2;
                cin = 1'b1;
            end
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_r4.sv
// Iterative radix-4 Booth multiplier, signed/unsigned per operation.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : booth_mult_r4_if.slave (flush, operand and result handshakes)
// Product is {result_hi, result}; overflow flags a product that does not fit
// in WIDTH bits for the selected mode. Latency N_ITER = WIDTH/2+1 edges.
// Optional: BOOTH_MULT_EARLY_TERM_EN finishes as soon as the unconsumed
// multiplier bits are all copies of the sign, giving 1..N_ITER edges.
module booth_mult_r4
    import booth_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    booth_mult_r4_if.slave bus
);

    localparam int unsigned N_ITER = n_iter(WIDTH);
    localparam int unsigned CW     = $clog2(N_ITER + 1);
    // {upper accumulator (WIDTH+3), multiplier / low product (WIDTH+2)}
    localparam int unsigned AW     = 2 * WIDTH + 5;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH+1:0] a_q, a_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             overflow_q, overflow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [2:0]       triplet;
    logic [WIDTH+2:0] pp;
    logic             cin;
    logic [WIDTH+2:0] h_sum;
    logic [AW-1:0]    step_acc;
    logic [AW-1:0]    final_acc;
    logic [2*WIDTH-1:0] prod;
    logic             last_step;
    logic             finish;
    logic             ovf;
`ifdef BOOTH_MULT_EARLY_TERM_EN
    logic             tail_uniform;
    int unsigned      rem_bits;
    int unsigned      shamt;
`endif

    assign triplet = {acc_q[1], acc_q[0], qm1_q};

    booth_r4_pp_gen #(
        .WIDTH(WIDTH)
    ) u_pp_gen (
        .triplet(triplet),
        .a_ext  (a_q),
        .pp     (pp),
        .cin    (cin)
    );

    // One Booth step: add digit*A into the upper half, then arithmetic >>2.
    always_comb begin
        h_sum     = acc_q[AW-1:WIDTH+2] + pp + {{(WIDTH+2){1'b0}}, cin};
        step_acc  = {{2{h_sum[WIDTH+2]}}, h_sum, acc_q[WIDTH+1:2]};
        last_step = (cnt_q == CW'(N_ITER - 1));
`ifdef BOOTH_MULT_EARLY_TERM_EN
        // After this step the low rem_bits of step_acc are still multiplier
        // bits and acc_q[1] becomes bit -1. If they all match, every remaining
        // digit is zero and only the outstanding shift is left to apply.
        rem_bits     = WIDTH - 2 * 32'(cnt_q);
        tail_uniform = 1'b1;
        for (int unsigned j = 0; j < WIDTH + 2; j++) begin
            if (j < rem_bits && step_acc[j] != acc_q[1]) begin
                tail_uniform = 1'b0;
            end
        end
        shamt     = 2 * (N_ITER - 1 - 32'(cnt_q));
        final_acc = $signed(step_acc) >>> shamt;
        finish    = last_step | tail_uniform;
`else
        final_acc = step_acc;
        finish    = last_step;
`endif
        prod = final_acc[2*WIDTH-1:0];
        if (signed_q) begin
            ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovf = |prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        qm1_d       = qm1_q;
        a_d         = a_q;
        signed_d    = signed_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}},
                           bus.multiplicand};
                    acc_d = {{(WIDTH+3){1'b0}},
                             {2{bus.is_signed & bus.multiplier[WIDTH-1]}},
                             bus.multiplier};
                    qm1_d      = 1'b0;
                    cnt_d      = '0;
                    signed_d   = bus.is_signed;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (finish) begin
                    acc_d       = final_acc;
                    cnt_d       = '0;
                    result_d    = prod[WIDTH-1:0];
                    result_hi_d = prod[2*WIDTH-1:WIDTH];
                    overflow_d  = ovf;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d = step_acc;
                    qm1_d = acc_q[1];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            qm1_q       <= 1'b0;
            a_q         <= '0;
            signed_q    <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            qm1_q       <= qm1_d;
            a_q         <= a_d;
            signed_q    <= signed_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 at WIDTH = 32, 16 and 8.
// Expected products come from a plain 64-bit multiply of the extended operands.
`timescale 1ns/1ps
module tb_booth_mult_r4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_mult_r4_if #(.WIDTH(32)) bus32 ();
    booth_mult_r4_if #(.WIDTH(16)) bus16 ();
    booth_mult_r4_if #(.WIDTH(8))  bus8 ();

    booth_mult_r4 #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    booth_mult_r4 #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    booth_mult_r4 #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

    // Index 0 = 32-bit, 1 = 16-bit, 2 = 8-bit instance.
    logic [2:0]       in_valid_v;
    logic             flush;
    logic             out_ready;
    logic             is_signed_s;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [2:0]       in_ready_v;
    logic [2:0]       out_valid_v;
    logic [2:0]       ovf_v;
    logic [2:0][31:0] res_lo;
    logic [2:0][31:0] res_hi;

    assign bus32.flush = flush;
    assign bus16.flush = flush;
    assign bus8.flush  = flush;
    assign bus32.out_ready = out_ready;
    assign bus16.out_ready = out_ready;
    assign bus8.out_ready  = out_ready;
    assign bus32.is_signed = is_signed_s;
    assign bus16.is_signed = is_signed_s;
    assign bus8.is_signed  = is_signed_s;
    assign bus32.in_valid = in_valid_v[0];
    assign bus16.in_valid = in_valid_v[1];
    assign bus8.in_valid  = in_valid_v[2];
    assign bus32.multiplicand = op_a;
    assign bus16.multiplicand = op_a[15:0];
    assign bus8.multiplicand  = op_a[7:0];
    assign bus32.multiplier = op_b;
    assign bus16.multiplier = op_b[15:0];
    assign bus8.multiplier  = op_b[7:0];

    assign in_ready_v  = {bus8.in_ready, bus16.in_ready, bus32.in_ready};
    assign out_valid_v = {bus8.out_valid, bus16.out_valid, bus32.out_valid};
    assign ovf_v       = {bus8.overflow, bus16.overflow, bus32.overflow};
    assign res_lo[0] = bus32.result;
    assign res_lo[1] = {16'h0, bus16.result};
    assign res_lo[2] = {24'h0, bus8.result};
    assign res_hi[0] = bus32.result_hi;
    assign res_hi[1] = {16'h0, bus16.result_hi};
    assign res_hi[2] = {24'h0, bus8.result_hi};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 32 : (k == 1) ? 16 : 8;
    endfunction

    function automatic logic [63:0] extend(input int w, input logic [31:0] x, input bit s);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << w) - 64'd1;
        v = {32'd0, x} & mask;
        if (s && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference: exact product of the extended operands, split into halves.
    function automatic void ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input bit s, output logic [31:0] lo,
                                    output logic [31:0] hi, output bit ov);
        logic [63:0] mask;
        logic [63:0] p;
        longint      sp;
        longint      lim;
        mask = (64'd1 << w) - 64'd1;
        p    = extend(w, a, s) * extend(w, b, s);
        lo   = 32'(p & mask);
        hi   = 32'((p >> w) & mask);
        if (s) begin
            sp  = $signed(p);
            lim = longint'(1) <<< (w - 1);
            ov  = (sp < -lim) || (sp >= lim);
        end else begin
            ov = (p >> w) != 64'd0;
        end
    endfunction

    // Edges from accept to out_valid.
    function automatic int exp_lat(input int w, input logic [31:0] b, input bit s);
        int n;
`ifdef BOOTH_MULT_EARLY_TERM_EN
        longint rest;
`endif
        n = w / 2 + 1;
`ifdef BOOTH_MULT_EARLY_TERM_EN
        for (int k = 1; k <= n; k++) begin
            rest = $signed(extend(w, b, s)) >>> (2 * k - 1);
            if (rest == 0 || rest == -1) return k;
        end
`endif
        return n;
    endfunction

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1;
            3: return 32'd1 << (w - 1);
            4: return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // All tasks start and end at a negedge.
    task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit s);
        int t;
        t = 0;
        while (!in_ready_v[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("start_timeout", 64'd0, 64'd1);
        op_a = a;
        op_b = b;
        is_signed_s = s;
        in_valid_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid_v[k] && lat < 60);
        if (!out_valid_v[k]) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic consume(input int k);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_out_valid", out_valid_v[k], 64'd0);
        chk("consume_in_ready", in_ready_v[k], 64'd1);
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit s,
                          input string tag, input logic [31:0] e_lo,
                          input logic [31:0] e_hi, input bit e_ov);
        int lat;
        start_op(k, a, b, s);
        wait_valid(k, lat);
        chk({tag, "_latency"}, lat, exp_lat(wid(k), b, s));
        chk({tag, "_lo"}, res_lo[k], e_lo);
        chk({tag, "_hi"}, res_hi[k], e_hi);
        chk({tag, "_ovf"}, ovf_v[k], e_ov);
        consume(k);
    endtask

    task automatic count_valid(input int k, input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_v[k]) seen++;
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_lo;
        logic [31:0] e_hi;
        bit          e_ov;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          lat;
        int          seen;

        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        in_valid_v = '0;
        op_a = '0;
        op_b = '0;
        is_signed_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready_v[0], 64'd1);
        chk("reset_out_valid", out_valid_v[0], 64'd0);
        chk("reset_result", res_lo[0], 64'd0);
        chk("reset_result_hi", res_hi[0], 64'd0);
        chk("reset_overflow", ovf_v[0], 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed corner products at WIDTH=32.
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, "s_min_x1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_xm1", 32'h8000_0000, 32'h0000_0000, 1'b1);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1_xm1", 32'h0000_0001, 32'h0000_0000, 1'b0);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_sq", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0002, 1'b0, "u_7f_x2", 32'hFFFF_FFFE, 32'h0000_0000, 1'b0);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0002, 1'b1, "s_7f_x2", 32'hFFFF_FFFE, 32'h0000_0000, 1'b1);

        // Backpressure: result holds, new request ignored while DONE.
        ref_mul(32, 32'h0000_1234, 32'h0000_5678, 1'b0, e_lo, e_hi, e_ov);
        start_op(0, 32'h0000_1234, 32'h0000_5678, 1'b0);
        wait_valid(0, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                op_a = 32'h0000_DEAD;
                op_b = 32'h0000_BEEF;
                in_valid_v[0] = 1'b1;
            end
            if (i == 4) in_valid_v[0] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", out_valid_v[0], 64'd1);
            chk("bp_in_ready", in_ready_v[0], 64'd0);
            chk("bp_lo", res_lo[0], e_lo);
            chk("bp_hi", res_hi[0], e_hi);
        end
        consume(0);
        chk("bp_lo_after", res_lo[0], e_lo);
        count_valid(0, 25, seen);
        chk("bp_no_queued_op", seen, 64'd0);

        // Flush at BUSY step 8 with a simultaneous request.
        start_op(0, 32'h1234_5678, 32'h5A5A_5A5A, 1'b1);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        in_valid_v[0] = 1'b1;
        op_a = 32'd7;
        op_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        chk("flush_in_ready", in_ready_v[0], 64'd1);
        chk("flush_out_valid", out_valid_v[0], 64'd0);
        // Still flushing while IDLE: the request must not be taken.
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid_v[0] = 1'b0;
        chk("flush_idle_not_accepted", in_ready_v[0], 64'd1);
        count_valid(0, 25, seen);
        chk("flush_never_valid", seen, 64'd0);
        run_op(0, 32'd3, 32'd5, 1'b0, "after_flush", 32'd15, 32'd0, 1'b0);

        // Async reset mid-BUSY.
        start_op(0, 32'h0BAD_F00D, 32'h7654_3210, 1'b0);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        chk("areset_in_ready", in_ready_v[0], 64'd1);
        chk("areset_out_valid", out_valid_v[0], 64'd0);
        chk("areset_result", res_lo[0], 64'd0);
        chk("areset_result_hi", res_hi[0], 64'd0);
        chk("areset_overflow", ovf_v[0], 64'd0);
        @(negedge clk);
        reset = 1'b1;
        count_valid(0, 25, seen);
        chk("areset_never_valid", seen, 64'd0);

        // Trivial multipliers (single-edge when early termination is built in).
        run_op(0, 32'd12345, 32'd0, 1'b1, "mul_by_zero", 32'd0, 32'd0, 1'b0);
        run_op(0, 32'd12345, 32'hFFFF_FFFF, 1'b1, "mul_by_m1", 32'hFFFF_CFC7, 32'hFFFF_FFFF, 1'b0);

        // Random sweep on every width.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 60; i++) begin
                a = pick(wid(k));
                b = pick(wid(k));
                s = 1'($urandom_range(0, 1));
                ref_mul(wid(k), a, b, s, e_lo, e_hi, e_ov);
                run_op(k, a, b, s, $sformatf("rnd_w%0d_%0d", wid(k), i), e_lo, e_hi, e_ov);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_r4.md
Name: booth_mult_r4

Overview:
Parametrised radix-4 Booth iterative multiplier, the successor to the 32-bit radix-2 multiplier in the execute stage. Retires two multiplier bits per cycle and supports a per-operation signed/unsigned mode. Returns the full 2*WIDTH product plus a low-half overflow flag. Uses a valid/ready handshake on both sides so the OoO issue logic can stall or flush it.

Parameters:
WIDTH, 32, operand width; must be even and >= 4
N_ITER, WIDTH/2+1, derived localparam, not overridable; radix-4 steps per operation

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort; drops any operation in flight
in_valid  input  1  operands valid
in_ready  output  1  block can accept an operation
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
multiplicand  input  WIDTH  operand A
multiplier  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  product[WIDTH-1:0]
result_hi  output  WIDTH  product[2*WIDTH-1:WIDTH]
overflow  output  1  product does not fit in WIDTH bits for the selected mode

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, overflow=0, iteration counter=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready is sampled, latch the operands and is_signed and go to BUSY.
  - BUSY: one radix-4 step per cycle. After N_ITER steps, go to DONE.
  - DONE: out_valid=1. out_ready=1 goes to IDLE. There is no IDLE-bypass: a new operation can only be accepted in the cycle after the result is consumed.
- Latency: out_valid rises exactly N_ITER edges after the accept edge (17 for WIDTH=32). With out_ready tied high, throughput is one operation per N_ITER+2 cycles.
- Operand extension: both operands are extended to WIDTH+2 bits, sign-extended if is_signed=1, zero-extended otherwise. The multiplier gets an implicit bit -1 = 0.
- Each step recodes triplet {b[2i+1], b[2i], b[2i-1]} to a digit in {0, +A, +2A, -A, -2A}. The partial product is added into the upper accumulator at WIDTH+3 bits. Negation is done by invert plus carry-in. The accumulator/multiplier register then shifts arithmetically right by 2.
- Final product: the low 2*WIDTH bits of the accumulator/multiplier register.
- Overflow, computed once when entering DONE and held:
  - signed: product[2W-1:W-1] not all-equal.
  - unsigned: product[2W-1:W] != 0.
- result, result_hi and overflow are stable while out_valid=1 and are only updated on entry to DONE.
- flush=1 in any state: go to IDLE next edge, out_valid=0, counter cleared. flush takes priority over in_valid and out_ready in the same cycle. result and result_hi keep their last values but are not valid.
- in_valid while not IDLE is ignored; no queuing.
- Async reset asserted mid-BUSY: immediate return to reset values. No partial result is ever presented.

Optional Feature:
BOOTH_MULT_EARLY_TERM_EN
- Defined: in BUSY, if all remaining unconsumed multiplier bits (including the extension bits) equal the current sign bit, the block finishes early. It applies the remaining arithmetic shift in one cycle and enters DONE. Latency is then variable, from 1 to N_ITER edges (e.g. 1 edge for multiplier=0 or -1). Product and overflow are identical to the fixed-latency path.
- Undefined: fixed N_ITER latency, and the early-termination logic is absent.

Decomposition:
- Package booth_mult_pkg holds:
  - FSM state encoding (IDLE, BUSY, DONE).
  - Radix-4 digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2).
  - A function computing N_ITER from WIDTH.
- Sub-module booth_r4_pp_gen: combinational; takes the 3-bit triplet and the extended multiplicand, and outputs the partial product (WIDTH+3 bits) and its carry-in. It is instantiated once in the datapath.

Test Plan:
- Signed, WIDTH=32: 0x80000000 * 0x00000001 -> result=0x80000000, result_hi=0xFFFFFFFF, overflow=0, out_valid exactly 17 edges after accept.
- Signed: 0x80000000 * 0xFFFFFFFF -> result=0x80000000, result_hi=0x00000000, overflow=1. Signed: 0xFFFFFFFF * 0xFFFFFFFF -> result=1, result_hi=0, overflow=0.
- Unsigned: 0xFFFFFFFF * 0xFFFFFFFF -> result=0x00000001, result_hi=0xFFFFFFFE, overflow=1. Unsigned: 0x7FFFFFFF * 2 -> result=0xFFFFFFFE, overflow=0. The same operands signed give overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> IDLE next edge, in_ready=1.
- Flush at BUSY step 8, with in_valid=1 in the same cycle -> IDLE, out_valid never asserts, and that in_valid is not accepted. The next operation 3*5 -> result=15, normal latency.
- Async reset pulse mid-BUSY -> all outputs at reset values immediately. With BOOTH_MULT_EARLY_TERM_EN defined: 12345 * 0 -> out_valid after 1 edge, result=0. Random signed/unsigned sweep at WIDTH=8 and 16 against a reference model.
